// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, access-type codes and lane helpers for the MEM-stage access unit
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RWAIT,
    ST_DONE
  } mau_state_e;

  // Byte-enable pattern for a lane-0 access of the given size; shifted by the offset later.
  function automatic logic [3:0] wstrb_base(input logic [2:0] f3);
    case (f3)
      F3_B:    wstrb_base = 4'b0001;
      F3_H:    wstrb_base = 4'b0011;
      F3_W:    wstrb_base = 4'b1111;
      default: wstrb_base = 4'b0000;
    endcase
  endfunction

  // Size/alignment legality; unsigned variants only exist for loads.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
    case (f3)
      F3_B:    access_legal = 1'b1;
      F3_H:    access_legal = ~off[0];
      F3_W:    access_legal = (off == 2'b00);
      F3_BU:   access_legal = ~is_store;
      F3_HU:   access_legal = ~is_store & ~off[0];
      default: access_legal = 1'b0;
    endcase
  endfunction

  // Replicate store data across lanes so the strobe alone picks the target bytes.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      F3_B:    lane_wdata = {4{sd[7:0]}};
      F3_H:    lane_wdata = {2{sd[15:0]}};
      default: lane_wdata = sd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// rtl/mem_access_unit_load_formatter.sv - aligns and extends a loaded word into the MDR value
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] mdr
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then sign- or zero-extend by access type.
  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    mdr = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   mdr = {24'h000000, byte_sel};
      F3_H:    mdr = {{16{half_sel[15]}}, half_sel};
      F3_HU:   mdr = {16'h0000, half_sel};
      default: mdr = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with request/grant/response bus handshake
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              stall,
  output logic [31:0]       mdr_dout,
  output logic              acc_fault
);

  mau_state_e state_q, state_d;

  // Request holding registers, loaded in the start cycle so REQ replays a stable request.
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  // Format selectors for the last completed load; stores leave them alone so mdr_dout holds.
  logic [1:0]  ld_off_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] rdata_q;

  logic              is_mem;
  logic              legal;
  logic              start;
  logic [ADDR_W-1:0] addr_word;
  logic [31:0]       wdata_new;
  logic [3:0]        wstrb_new;

  assign is_mem    = mem_valid & (mem_rd | mem_wr);
  assign legal     = access_legal(funct3, addr[1:0], mem_wr);
  assign start     = is_mem & legal & ~rst;
  assign addr_word = {addr[ADDR_W-1:2], 2'b00};
  assign wdata_new = lane_wdata(funct3, store_data);
  assign wstrb_new = mem_wr ? (wstrb_base(funct3) << addr[1:0]) : 4'b0000;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and bus/pipeline outputs; the first request cycle is driven straight from EX/MEM.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = 32'h0;
    bus_wstrb = 4'h0;
    stall     = 1'b0;
    acc_fault = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bus_req   = 1'b1;
          bus_we    = mem_wr;
          bus_addr  = addr_word;
          bus_wdata = wdata_new;
          bus_wstrb = wstrb_new;
          stall     = 1'b1;
          if (bus_gnt) begin
            state_d = mem_wr ? ST_DONE : ST_RWAIT;
          end else begin
            state_d = ST_REQ;
          end
        end else if (is_mem & ~rst) begin
          acc_fault = 1'b1;
        end
      end
      ST_REQ: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_wstrb = wstrb_q;
        stall     = 1'b1;
        if (bus_gnt) begin
          state_d = we_q ? ST_DONE : ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the request in the start cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
    end else if (state_q == ST_IDLE && start) begin
      off_q   <= addr[1:0];
      f3_q    <= funct3;
      we_q    <= mem_wr;
      addr_q  <= addr_word;
      wdata_q <= wdata_new;
      wstrb_q <= wstrb_new;
    end
  end

  // Capture read data only while waiting for it; stray rvalid elsewhere is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 32'h0;
      ld_off_q <= 2'b00;
      ld_f3_q  <= 3'b000;
    end else if (state_q == ST_RWAIT && bus_rvalid) begin
      rdata_q  <= bus_rdata;
      ld_off_q <= off_q;
      ld_f3_q  <= f3_q;
    end
  end

  load_formatter u_load_formatter (
    .rdata  (rdata_q),
    .off    (ld_off_q),
    .funct3 (ld_f3_q),
    .mdr    (mdr_dout)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall, acc_fault;
  logic [31:0] mdr_dout;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .mdr_dout   (mdr_dout),
    .acc_fault  (acc_fault)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mdr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  localparam int NVEC = 14;
  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          n_vec = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_mdr = 32'h0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input int gd,
                              input int rvd, input logic [31:0] rdat, input logic flt,
                              input logic [31:0] wd, input logic [3:0] ws,
                              input logic [31:0] md);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd; v.gd = gd; v.rvd = rvd;
    v.rdata = rdat; v.fault = flt; v.wdata = wd; v.wstrb = ws; v.mdr = md;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    logic granted;
    logic done;
    int   gcyc;
    int   nstall;
    int   exp_stall;
    v = vecs[idx];
    @(posedge clk); #1;
    mem_valid  = 1'b1;
    mem_rd     = v.rd;
    mem_wr     = v.wr;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    if (!v.fault) begin
      e.addr  = {v.addr[31:2], 2'b00};
      e.we    = v.wr;
      e.wdata = v.wdata;
      e.wstrb = v.wstrb;
      sb_q.push_back(e);
    end
    granted = 1'b0;
    done    = 1'b0;
    gcyc    = -100;
    nstall  = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      bus_gnt    = !granted && (cyc == v.gd);
      bus_rvalid = granted && v.rd && (cyc == gcyc + v.rvd);
      bus_rdata  = bus_rvalid ? v.rdata : 32'h5A5A5A5A;
      @(negedge clk);
      if (cyc == 0) begin
        chk($sformatf("v%0d acc_fault", idx), 32'(acc_fault), 32'(v.fault));
      end
      if (stall) nstall++;
      if (v.fault) begin
        chk($sformatf("v%0d bus_req on fault", idx), 32'(bus_req), 32'h0);
      end else if (bus_req) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d unexpected bus_req", idx), 32'h1, 32'h0);
        end else begin
          chk($sformatf("v%0d bus_addr", idx), bus_addr, sb_q[0].addr);
          chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(sb_q[0].we));
          chk($sformatf("v%0d bus_wstrb", idx), 32'(bus_wstrb), 32'(sb_q[0].wstrb));
          if (sb_q[0].we) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, sb_q[0].wdata);
          if (bus_gnt) begin
            void'(sb_q.pop_front());
            granted = 1'b1;
            gcyc    = cyc;
          end
        end
      end
      if (granted && cyc == gcyc + 1) begin
        chk($sformatf("v%0d bus_req after grant", idx), 32'(bus_req), 32'h0);
      end
      if (!stall) done = 1'b1;
    end
    if (!done) chk($sformatf("v%0d timeout", idx), 32'h1, 32'h0);
    exp_stall = v.fault ? 0 : (1 + v.gd + (v.rd ? v.rvd : 0));
    chk($sformatf("v%0d stall cycles", idx), 32'(nstall), 32'(exp_stall));
    if (v.rd && !v.fault) last_mdr = v.mdr;
    chk($sformatf("v%0d mdr_dout", idx), mdr_dout, last_mdr);
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 1, F3_W,   32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0);
    vecs[1]  = mk(0, 1, F3_B,   32'h103, 32'h000000A5, 0, 0, 32'h0,        0, 32'hA5A5A5A5, 4'b1000, 32'h0);
    vecs[2]  = mk(1, 0, F3_B,   32'h102, 32'h0,        0, 2, 32'h12803456, 0, 32'h0,        4'b0000, 32'hFFFFFF80);
    vecs[3]  = mk(1, 0, F3_BU,  32'h102, 32'h0,        1, 1, 32'h12803456, 0, 32'h0,        4'b0000, 32'h00000080);
    vecs[4]  = mk(1, 0, F3_H,   32'h101, 32'h0,        0, 1, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[5]  = mk(0, 1, F3_H,   32'h102, 32'h1234BEEF, 2, 0, 32'h0,        0, 32'hBEEFBEEF, 4'b1100, 32'h0);
    vecs[6]  = mk(1, 0, F3_HU,  32'h102, 32'h0,        1, 1, 32'h80017FFF, 0, 32'h0,        4'b0000, 32'h00008001);
    vecs[7]  = mk(1, 0, F3_H,   32'h100, 32'h0,        0, 3, 32'h8001F00D, 0, 32'h0,        4'b0000, 32'hFFFFF00D);
    vecs[8]  = mk(1, 0, F3_W,   32'h204, 32'h0,        1, 1, 32'hCAFEBABE, 0, 32'h0,        4'b0000, 32'hCAFEBABE);
    vecs[9]  = mk(0, 1, F3_W,   32'h102, 32'h11111111, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[10] = mk(0, 1, 3'b011, 32'h000, 32'h22222222, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[11] = mk(1, 0, 3'b110, 32'h000, 32'h0,        0, 1, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[12] = mk(1, 0, F3_B,   32'h101, 32'h0,        0, 1, 32'h00007F00, 0, 32'h0,        4'b0000, 32'h0000007F);
    vecs[13] = mk(0, 1, F3_B,   32'h100, 32'hFFFFFF3C, 1, 0, 32'h0,        0, 32'h3C3C3C3C, 4'b0001, 32'h0);

    rst = 1'b1; mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset bus_req",   32'(bus_req),   32'h0);
    chk("reset bus_we",    32'(bus_we),    32'h0);
    chk("reset bus_addr",  bus_addr,       32'h0);
    chk("reset bus_wdata", bus_wdata,      32'h0);
    chk("reset bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("reset stall",     32'(stall),     32'h0);
    chk("reset acc_fault", 32'(acc_fault), 32'h0);
    chk("reset mdr_dout",  mdr_dout,       32'h0);

    for (int i = 0; i < NVEC; i++) run_vec(i);
    chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

    // LW with grant withheld three cycles, then reset while waiting for data.
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = F3_W; addr = 32'h300;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d bus_req", c), 32'(bus_req), 32'h1);
      chk($sformatf("hold c%0d bus_addr", c), bus_addr, 32'h300);
      chk($sformatf("hold c%0d stall", c), 32'(stall), 32'h1);
      @(posedge clk); #1;
      if (c == 0) addr = 32'hFFF0;
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("grant cycle bus_req", 32'(bus_req), 32'h1);
    chk("grant cycle bus_addr", bus_addr, 32'h300);
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("rwait stall", 32'(stall), 32'h1);
    chk("rwait bus_req", 32'(bus_req), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b0; mem_rd = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("post-rst bus_req",   32'(bus_req),   32'h0);
    chk("post-rst bus_we",    32'(bus_we),    32'h0);
    chk("post-rst bus_addr",  bus_addr,       32'h0);
    chk("post-rst bus_wdata", bus_wdata,      32'h0);
    chk("post-rst bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("post-rst stall",     32'(stall),     32'h0);
    chk("post-rst acc_fault", 32'(acc_fault), 32'h0);
    chk("post-rst mdr_dout",  mdr_dout,       32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("late rvalid mdr_dout", mdr_dout, 32'h0);
    chk("late rvalid stall", 32'(stall), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
